// File: rtl/nmos_clk_gen_if.sv
// Control and phase-output bundle between a clock-gen controller and nmos_clk_gen.
// The master drives run/step/lengths and the slave (the generator) returns phases and status.
interface nmos_clk_gen_if #(
    parameter int CNT_W = 8,
    parameter int PER_W = 16
);
    logic             run;
    logic             step;
    logic [CNT_W-1:0] ph1_len;
    logic [CNT_W-1:0] ph2_len;
    logic [CNT_W-1:0] gap_len;
    logic             phi1;
    logic             phi2;
    logic             phi1_rise;
    logic             phi1_fall;
    logic             phi2_rise;
    logic             phi2_fall;
    logic             busy;
    logic [PER_W-1:0] period_cnt;

    modport master (
        output run, step, ph1_len, ph2_len, gap_len,
        input  phi1, phi2, phi1_rise, phi1_fall, phi2_rise, phi2_fall, busy, period_cnt
    );

    modport slave (
        input  run, step, ph1_len, ph2_len, gap_len,
        output phi1, phi2, phi1_rise, phi1_fall, phi2_rise, phi2_fall, busy, period_cnt
    );
endinterface

// File: rtl/nmos_clk_gen.sv
// Two-phase non-overlapping clock generator producing PHI1/PHI2 enables for NMOS latch cells.
// state  | meaning
// IDLE   | stopped, both phases low
// PH1    | phi1 high for the captured ph1 length
// GAP12  | dead time after PHI1, both low
// PH2    | phi2 high for the captured ph2 length
// GAP21  | dead time after PHI2; period ends here
module nmos_clk_gen #(
    parameter int CNT_W = 8,
    parameter int PER_W = 16
) (
    input  logic               main_clk,
    input  logic               main_rst_n,
    nmos_clk_gen_if.slave      cg
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PH1   = 3'd1,
        S_GAP12 = 3'd2,
        S_PH2   = 3'd3,
        S_GAP21 = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ph1_sh_q, ph1_sh_d;
    logic [CNT_W-1:0] ph2_sh_q, ph2_sh_d;
    logic [CNT_W-1:0] gap_sh_q, gap_sh_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             phi1_q, phi1_d;
    logic             phi2_q, phi2_d;
    logic             busy_q, busy_d;
    logic [3:0]       strb_q, strb_d;   // {phi1_rise, phi1_fall, phi2_rise, phi2_fall}
    logic             tc;
    logic             start;

    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph1_sh_d = ph1_sh_q;
        ph2_sh_d = ph2_sh_q;
        gap_sh_d = gap_sh_q;
        period_d = period_q;
        start    = 1'b0;
        tc       = (cnt_q == '0);

        if (state_q != S_IDLE && !tc) begin
            cnt_d = cnt_q - ONE;
        end

        case (state_q)
            S_IDLE: begin
                start = cg.run | cg.step;
            end
            S_PH1: begin
                if (tc) begin
                    state_d = S_GAP12;
                    cnt_d   = gap_sh_q - ONE;
                end
            end
            S_GAP12: begin
                if (tc) begin
                    state_d = S_PH2;
                    cnt_d   = ph2_sh_q - ONE;
                end
            end
            S_PH2: begin
                if (tc) begin
                    state_d = S_GAP21;
                    cnt_d   = gap_sh_q - ONE;
                end
            end
            S_GAP21: begin
                if (tc) begin
                    period_d = period_q + PER_W'(1);
                    start    = cg.run;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Lengths are frozen for the whole period at the moment PH1 is entered.
        if (start) begin
            state_d  = S_PH1;
            ph1_sh_d = clamp1(cg.ph1_len);
            ph2_sh_d = clamp1(cg.ph2_len);
            gap_sh_d = clamp1(cg.gap_len);
            cnt_d    = clamp1(cg.ph1_len) - ONE;
        end

        phi1_d = (state_d == S_PH1);
        phi2_d = (state_d == S_PH2);
        busy_d = (state_d != S_IDLE);
        strb_d = {phi1_d & ~phi1_q, ~phi1_d & phi1_q, phi2_d & ~phi2_q, ~phi2_d & phi2_q};
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ph1_sh_q <= ONE;
            ph2_sh_q <= ONE;
            gap_sh_q <= ONE;
            period_q <= '0;
            phi1_q   <= 1'b0;
            phi2_q   <= 1'b0;
            busy_q   <= 1'b0;
            strb_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph1_sh_q <= ph1_sh_d;
            ph2_sh_q <= ph2_sh_d;
            gap_sh_q <= gap_sh_d;
            period_q <= period_d;
            phi1_q   <= phi1_d;
            phi2_q   <= phi2_d;
            busy_q   <= busy_d;
            strb_q   <= strb_d;
        end
    end

    assign cg.phi1       = phi1_q;
    assign cg.phi2       = phi2_q;
    assign cg.phi1_rise  = strb_q[3];
    assign cg.phi1_fall  = strb_q[2];
    assign cg.phi2_rise  = strb_q[1];
    assign cg.phi2_fall  = strb_q[0];
    assign cg.busy       = busy_q;
    assign cg.period_cnt = period_q;

endmodule

// File: doc/nmos_clk_gen.md
# nmos_clk_gen

Two-phase non-overlapping clock generator for the NMOS simulation library. It derives the PHI1/PHI2 phase enables that drive the C1/C2 inputs of every NMOS latch and register cell from the single simulation clock. It sits directly upstream of the NMOS register cells. Phase widths and dead time are programmable, and run/single-step control is provided for debug.

## Interface
Parameters:
- CNT_W, 8, width of the phase-length fields and of the internal phase counter.
- PER_W, 16, width of the completed-period counter.

Ports:
- main_clk  in  1  simulation master clock; all state changes on its rising edge. One clock domain only.
- main_rst_n  in  1  asynchronous, active-low reset.
- run  in  1  free-running enable.
- step  in  1  single-period request pulse; honoured only in IDLE with run=0.
- ph1_len  in  CNT_W  PHI1 high width, in main_clk cycles.
- ph2_len  in  CNT_W  PHI2 high width, in main_clk cycles.
- gap_len  in  CNT_W  dead time between phases, in main_clk cycles.
- phi1  out  1  PHI1 phase, registered (drives C1).
- phi2  out  1  PHI2 phase, registered (drives C2).
- phi1_rise, phi1_fall, phi2_rise, phi2_fall  out  1  single-cycle edge strobes.
- busy  out  1  high whenever the FSM is not in IDLE.
- period_cnt  out  PER_W  count of completed periods, wraps modulo 2^PER_W.

## Operation
- FSM states: IDLE, PH1, GAP12, PH2, GAP21.
  - IDLE: phi1=0, phi2=0.
  - PH1: phi1=1.
  - GAP12: both outputs 0.
  - PH2: phi2=1.
  - GAP21: both outputs 0.
- Transitions:
  - IDLE -> PH1 when run=1, or when step=1 and run=0.
  - PH1 -> GAP12 -> PH2 -> GAP21, each state left when its length expires.
  - GAP21 -> PH1 when run=1; otherwise GAP21 -> IDLE.
- State lengths:
  - Each length field is effectively max(len, 1). A value of 0 is treated as 1, so a zero gap still yields one cycle with both outputs low.
  - phi1 and phi2 are never high in the same cycle, under any input sequence.
- Config capture: ph1_len, ph2_len and gap_len are sampled into shadow registers on every entry to PH1 and are held for the whole period. Changing them mid-period has no effect until the next period.
- Run and step:
  - Deasserting run never truncates a period. The current period completes through GAP21, then the FSM enters IDLE.
  - step while busy=1 or run=1 is ignored. It is not queued.
- period_cnt increments by 1 on every exit from GAP21, whether the next state is PH1 or IDLE.
- Edge strobes:
  - Each strobe is high for exactly the one cycle in which the corresponding registered phi output has just changed.
  - Strobes are combinational from registered state or registered themselves, and are always glitch-free and aligned with phi.
- Reset (async assert, any state, including mid-period):
  - FSM -> IDLE.
  - phi1=0, phi2=0, all strobes 0, busy=0, period_cnt=0, shadow lengths=1.
  - Outputs go low immediately on assertion, not at the next clock edge.

## Timing
- Latency: the first main_clk edge with run=1 (or step=1) in IDLE sets phi1=1 on that edge.
- Period length = L1 + G + L2 + G main_clk cycles, where L1, L2 and G are the clamped lengths.
- Back-to-back periods under run=1 have no idle cycle: PH1 follows GAP21 directly.
- Reset deassertion: the first state change occurs at the first main_clk rising edge after main_rst_n rises.
- Strobe/phi alignment: phi1_rise=1 in the same cycle as the first phi1=1 cycle. phi1_fall=1 in the first phi1=0 cycle of GAP12. The same rules apply to phi2.

## Test plan
- Free-run, run=1, ph1=3, gap=1, ph2=3 -> 8-cycle period. phi1 high in cycles 1-3, both low in cycle 4, phi2 high in cycles 5-7, both low in cycle 8. period_cnt=1 after cycle 8, and phi1 high again in cycle 9.
- All lengths 0 -> period of 4 cycles (1/1/1/1). phi1 and phi2 never both high. Each strobe fires once per period.
- Change ph1_len from 3 to 5 during PH2 -> current period unchanged. The next PH1 lasts 5 cycles.
- Drop run in the middle of PH1 (ph1=4, gap=2, ph2=4) -> the period completes all 12 cycles, then busy=0 in IDLE. period_cnt incremented by exactly 1.
- run=0, step pulse in IDLE -> exactly one period, then IDLE. A second step issued while busy is ignored.
- Assert main_rst_n=0 mid-PH2 -> phi2=0 and busy=0 immediately, period_cnt=0. After release with run=1, phi1 rises on the first main_clk edge.
